// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Op decoding helpers live here so datapath and bench agree on them.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MADD  = 3'b100;
    localparam logic [2:0] MDU_MADDU = 3'b101;
    localparam logic [2:0] MDU_MSUB  = 3'b110;
    localparam logic [2:0] MDU_MSUBU = 3'b111;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MUL   = 3'd1;
    localparam logic [2:0] ST_DIV   = 3'd2;
    localparam logic [2:0] ST_FIXUP = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    localparam int MDU_ITER    = 32;
    localparam int MDU_LATENCY = 35;

    function automatic logic op_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on magnitudes: shift in the next dividend
// bit, subtract the divisor when it fits, shift the quotient bit in.
module mdu_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quot,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quot_next
);

    logic [W:0] shifted;
    logic [W:0] diff;
    logic       fits;

    // rem < divisor, so the difference always fits in W+1 signed bits
    assign shifted   = {rem, quot[W-1]};
    assign diff      = shifted - {1'b0, divisor};
    assign fits      = ~diff[W];
    assign rem_next  = fits ? diff[W-1:0] : shifted[W-1:0];
    assign quot_next = {quot[W-2:0], fits};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit feeding the Hi/Lo register file.
// Fixed latency from Start to Busy low, one Hi/Lo strobe per accepted op.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_ITER
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic [DATA_WIDTH-1:0] OperandA,
    input  logic [DATA_WIDTH-1:0] OperandB,
    input  logic                  Flush,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] HiData,
    output logic [DATA_WIDTH-1:0] LoData,
    output logic                  HiLoWriteEn,
    output logic                  HiLoMadd,
    output logic                  HiLoMsub
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    logic [2:0]     state;
    logic [2:0]     op_q;
    logic           sa;
    logic           sb;
    logic           divz;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   opa;

    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [2*W-1:0] mul_fix;
    logic [W-1:0]   rem_next;
    logic [W-1:0]   quot_next;
    logic [W-1:0]   quot_fix;
    logic [W-1:0]   rem_fix;
    logic           flush_now;
    logic           wr_sel;
    logic           madd_sel;
    logic           msub_sel;

    assign a_neg = op_signed(Op) & OperandA[W-1];
    assign b_neg = op_signed(Op) & OperandB[W-1];
    assign a_mag = a_neg ? -OperandA : OperandA;
    assign b_mag = b_neg ? -OperandB : OperandB;

    // acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[2*W-1:W]}
                    + (acc[0] ? {1'b0, opa} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc[W-1:1]};

    mdu_div_step #(
        .W(W)
    ) u_step (
        .rem      (acc[2*W-1:W]),
        .quot     (acc[W-1:0]),
        .divisor  (opa),
        .rem_next (rem_next),
        .quot_next(quot_next)
    );

    assign mul_fix  = (op_signed(op_q) && (sa ^ sb)) ? -acc : acc;
    assign quot_fix = (op_signed(op_q) && (sa ^ sb) && !divz)
                    ? -acc[W-1:0] : acc[W-1:0];
    assign rem_fix  = (op_signed(op_q) && sa && !divz)
                    ? -acc[2*W-1:W] : acc[2*W-1:W];

    assign flush_now = Flush && (state != ST_IDLE);

    always_comb begin
        wr_sel   = 1'b0;
        madd_sel = 1'b0;
        msub_sel = 1'b0;
        unique case (1'b1)
            !op_q[2]:            wr_sel   = 1'b1;
            op_q[2] && !op_q[1]: madd_sel = 1'b1;
            op_q[2] && op_q[1]:  msub_sel = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            divz        <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            opa         <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            HiData      <= '0;
            LoData      <= '0;
            HiLoWriteEn <= 1'b0;
            HiLoMadd    <= 1'b0;
            HiLoMsub    <= 1'b0;
        end else begin
            Done        <= 1'b0;
            HiLoWriteEn <= 1'b0;
            HiLoMadd    <= 1'b0;
            HiLoMsub    <= 1'b0;
            if (flush_now) begin
                state <= ST_IDLE;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        Busy <= Start;
                        if (Start) begin
                            op_q <= Op;
                            sa   <= a_neg;
                            sb   <= b_neg;
                            cnt  <= CW'(W);
                            opa  <= op_is_div(Op) ? b_mag : a_mag;
                            if (!op_is_div(Op)) begin
                                divz  <= 1'b0;
                                acc   <= {{W{1'b0}}, b_mag};
                                state <= ST_MUL;
                            end else if (OperandB == '0) begin
                                // result preloaded; FIXUP just burns the latency
                                divz  <= 1'b1;
                                acc   <= {OperandA, {W{1'b1}}};
                                state <= ST_FIXUP;
                            end else begin
                                divz  <= 1'b0;
                                acc   <= {{W{1'b0}}, a_mag};
                                state <= ST_DIV;
                            end
                        end
                    end
                    ST_MUL: begin
                        acc <= mul_next;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= ST_FIXUP;
                    end
                    ST_DIV: begin
                        acc <= {rem_next, quot_next};
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= ST_FIXUP;
                    end
                    ST_FIXUP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else begin
                            acc   <= op_is_div(op_q)
                                   ? {rem_fix, quot_fix} : mul_fix;
                            state <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        HiData      <= acc[2*W-1:W];
                        LoData      <= acc[W-1:0];
                        HiLoWriteEn <= wr_sel;
                        HiLoMadd    <= madd_sel;
                        HiLoMsub    <= msub_sel;
                        Done        <= 1'b1;
                        state       <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed results.
// Checks values, strobe type, latency, flush, reset and back-to-back issue.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        Flush;
    logic        Busy;
    logic        Done;
    logic [31:0] HiData;
    logic [31:0] LoData;
    logic        HiLoWriteEn;
    logic        HiLoMadd;
    logic        HiLoMsub;

    logic [31:0] dr, dq, dd, nr, nq;

    int n_vec = 0;
    int n_err = 0;

    mult_div_unit #(
        .DATA_WIDTH(32)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .Op         (Op),
        .OperandA   (OperandA),
        .OperandB   (OperandB),
        .Flush      (Flush),
        .Busy       (Busy),
        .Done       (Done),
        .HiData     (HiData),
        .LoData     (LoData),
        .HiLoWriteEn(HiLoWriteEn),
        .HiLoMadd   (HiLoMadd),
        .HiLoMsub   (HiLoMsub)
    );

    mdu_div_step #(
        .W(32)
    ) u_ref_step (
        .rem      (dr),
        .quot     (dq),
        .divisor  (dd),
        .rem_next (nr),
        .quot_next(nq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic logic any_stb();
        return HiLoWriteEn | HiLoMadd | HiLoMsub;
    endfunction

    // Issue at a negedge, then watch until Busy drops (bounded).
    task automatic run_op(input string tag,
                          input logic [2:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] eh,
                          input logic [31:0] el,
                          input logic [2:0] estb);
        int         busy_n;
        int         stb_n;
        int         stb_at;
        logic [3:0] seen;
        Start    = 1'b1;
        Op       = op;
        OperandA = a;
        OperandB = b;
        @(negedge Clk);
        Start    = 1'b0;
        Op       = 3'($urandom);
        OperandA = $urandom;
        OperandB = $urandom;
        busy_n   = 0;
        stb_n    = 0;
        stb_at   = 0;
        seen     = '0;
        while (Busy && busy_n < 100) begin
            busy_n++;
            if (any_stb() || Done) begin
                stb_n++;
                stb_at = busy_n;
                seen   = {Done, HiLoWriteEn, HiLoMadd, HiLoMsub};
            end
            @(negedge Clk);
        end
        check({tag, " busy"}, 64'(busy_n), 64'(MDU_LATENCY));
        check({tag, " stb_at"}, 64'(stb_at), 64'(MDU_LATENCY));
        check({tag, " stb_n"}, 64'(stb_n), 64'd1);
        check({tag, " stb"}, 64'(seen), 64'({1'b1, estb}));
        check({tag, " hi"}, 64'(HiData), 64'(eh));
        check({tag, " lo"}, 64'(LoData), 64'(el));
    endtask

    initial begin
        int         n;
        int         stb_at;
        int         stb_n;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;

        Rst      = 1'b1;
        Start    = 1'b0;
        Flush    = 1'b0;
        Op       = '0;
        OperandA = '0;
        OperandB = '0;
        dr = 32'd3; dq = 32'h8000_0000; dd = 32'd5;
        #1;
        check("step sub", {nr, nq}, {32'd2, 32'd1});
        dr = 32'd1; dq = 32'h0000_0000; dd = 32'd5;
        #1;
        check("step keep", {nr, nq}, {32'd2, 32'd0});

        repeat (2) @(negedge Clk);
        check("rst ctl",
              64'({Busy, Done, HiLoWriteEn, HiLoMadd, HiLoMsub}), 64'd0);
        check("rst data", {HiData, LoData}, 64'd0);
        Rst = 1'b0;
        @(negedge Clk);

        run_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 3'b100);
        run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 3'b100);
        run_op("madd", MDU_MADD, 32'd2, 32'hFFFF_FFFD,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 3'b010);
        run_op("maddu", MDU_MADDU, 32'h8000_0000, 32'd2,
               32'd1, 32'd0, 3'b010);
        run_op("msubu", MDU_MSUBU, 32'h0001_0000, 32'h0001_0000,
               32'd1, 32'd0, 3'b001);
        run_op("div n/p", MDU_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 3'b100);
        run_op("div p/n", MDU_DIV, 32'd7, 32'hFFFF_FFFE,
               32'd1, 32'hFFFF_FFFD, 3'b100);
        run_op("divu", MDU_DIVU, 32'd100, 32'd7,
               32'd2, 32'd14, 3'b100);
        run_op("div min", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, 3'b100);
        run_op("div s/0", MDU_DIV, 32'hFFFF_FFFB, 32'd0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF, 3'b100);
        run_op("divu /0", MDU_DIVU, 32'd5, 32'd0,
               32'd5, 32'hFFFF_FFFF, 3'b100);

        // Flush at E10: nothing written, Hi/Lo hold the last result
        hold_hi  = HiData;
        hold_lo  = LoData;
        Start    = 1'b1;
        Op       = MDU_MULTU;
        OperandA = 32'd3;
        OperandB = 32'd4;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush busy", 64'(Busy), 64'd0);
        stb_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (any_stb() || Done || Busy) stb_n++;
            @(negedge Clk);
        end
        check("flush quiet", 64'(stb_n), 64'd0);
        check("flush hold", {HiData, LoData}, {hold_hi, hold_lo});

        // Back-to-back with Start held: MULT then DIV accepted at E35
        Start    = 1'b1;
        Op       = MDU_MULT;
        OperandA = 32'd7;
        OperandB = 32'hFFFF_FFFA;
        @(negedge Clk);
        Op       = MDU_DIV;
        OperandA = 32'd100;
        OperandB = 32'hFFFF_FFF9;
        n        = 1;
        stb_at   = 0;
        while (stb_at == 0 && n < 100) begin
            if (any_stb()) stb_at = n;
            else begin
                @(negedge Clk);
                n++;
            end
        end
        check("b2b first at", 64'(stb_at), 64'd35);
        check("b2b first", {HiData, LoData}, 64'hFFFF_FFFF_FFFF_FFD6);
        @(negedge Clk);
        n++;
        Start    = 1'b0;
        OperandA = $urandom;
        OperandB = $urandom;
        check("b2b busy", 64'(Busy), 64'd1);
        stb_at = 0;
        while (stb_at == 0 && n < 200) begin
            if (any_stb()) stb_at = n;
            else begin
                @(negedge Clk);
                n++;
            end
        end
        check("b2b second at", 64'(stb_at), 64'd70);
        check("b2b second", {HiData, LoData}, {32'd2, 32'hFFFF_FFF2});
        n = 0;
        while (Busy && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check("b2b idle", 64'(Busy), 64'd0);

        // Async reset at E20 of a MULT
        Start    = 1'b1;
        Op       = MDU_MULT;
        OperandA = 32'd9;
        OperandB = 32'd9;
        @(negedge Clk);
        Start = 1'b0;
        repeat (19) @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("arst ctl",
              64'({Busy, Done, HiLoWriteEn, HiLoMadd, HiLoMsub}), 64'd0);
        check("arst data", {HiData, LoData}, 64'd0);
        @(negedge Clk);
        Rst   = 1'b0;
        stb_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (any_stb() || Done || Busy) stb_n++;
            @(negedge Clk);
        end
        check("arst quiet", 64'(stb_n), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
